// File: rtl/sram_controller_pkg.sv
// Shared state encoding, default parameters and SRAM bus widths for the
// 32-bit to 16-bit half-word SRAM controller.
package sram_controller_pkg;

   localparam int unsigned DEF_BASE_ADDR   = 1024;
   localparam int unsigned DEF_WAIT_CYCLES = 2;
   localparam int unsigned SRAM_DQ_W       = 16;
   localparam int unsigned SRAM_ADDR_W     = 19;
   localparam int unsigned WAIT_CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_e;

   // Half-word SRAM address: word index with the half-select as LSB.
   function automatic logic [SRAM_ADDR_W-1:0] half_addr(
      input logic [SRAM_ADDR_W-2:0] idx,
      input logic                   upper
   );
      return {idx, upper};
   endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU access into two 16-bit SRAM accesses (low half then
// high half), followed by a fixed settle period, and stalls the requester meanwhile.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
      (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                    op_wr_q, op_wr_d;
   logic [31:0]             read_data_q, read_data_d;
   logic [SRAM_ADDR_W-2:0]  word_idx_q, word_idx_d;
   logic [31:0]             wdata_q, wdata_d;

   logic [31:0]             off;
   logic                    unused_off;
   logic                    req;
   logic                    dq_oe;
   logic [SRAM_DQ_W-1:0]    dq_out;

   assign req        = rd_en | wr_en;
   assign off        = address - 32'(BASE_ADDR);
   assign unused_off = ^{off[31:20], off[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         op_wr_q     <= 1'b0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         op_wr_q     <= op_wr_d;
         read_data_q <= read_data_d;
      end
   end

   // Request address and data are captured once so the requester may change them mid-access.
   always_ff @(posedge clk) begin
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      unique case (state_q)
         IDLE: if (req) state_d = LO;
         LO:   state_d = HI;
         HI:   state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
         WAIT: begin
            if (wait_cnt_q == WAIT_LAST) state_d = DONE;
            else                         wait_cnt_d = wait_cnt_q + 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_wr_d     = op_wr_q;
      word_idx_d  = word_idx_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      if (state_q == IDLE && req) begin
         op_wr_d    = wr_en;
         word_idx_d = off[19:2];
         wdata_d    = write_data;
      end
      if (!op_wr_q && state_q == LO) read_data_d[15:0]  = SRAM_DQ;
      if (!op_wr_q && state_q == HI) read_data_d[31:16] = SRAM_DQ;
   end

   // Holding rst low kills the write strobe in the same cycle so an aborted write stops at once.
   always_comb begin
      ready     = 1'b0;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
      dq_out    = '0;
      unique case (state_q)
         IDLE: ready = !req;
         LO: begin
            SRAM_ADDR = half_addr(word_idx_q, 1'b0);
            dq_out    = wdata_q[15:0];
            dq_oe     = op_wr_q && rst;
         end
         HI: begin
            SRAM_ADDR = half_addr(word_idx_q, 1'b1);
            dq_out    = wdata_q[31:16];
            dq_oe     = op_wr_q && rst;
         end
         WAIT: ready = 1'b0;
         DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
      SRAM_WE_N = !dq_oe;
   end

   assign SRAM_DQ   = dq_oe ? dq_out : 'z;
   assign read_data = read_data_q;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two builds (default settle and zero settle), each
// paired with a 64-entry half-word SRAM model, checked through a scoreboard.
module tb_sram_controller;

   localparam int W_A = 2;
   localparam int W_Z = 0;

   logic        clk, rst, wr_en, rd_en, sel, mdl_init, mon_b2b;
   logic [31:0] address, write_data;
   logic [31:0] last_rd;
   int          n_vec = 0;
   int          n_miss = 0;
   int          we_low = 0;

   logic        wr_a, rd_a, ready_a, we_a, ub_a, lb_a, ce_a, oe_a;
   logic        wr_z, rd_z, ready_z, we_z, ub_z, lb_z, ce_z, oe_z;
   logic [31:0] rdata_a, rdata_z;
   logic [18:0] addr_a, addr_z;
   wire  [15:0] dq_a, dq_z;
   logic [15:0] mem_a [64];
   logic [15:0] mem_z [64];
   logic        cur_ready;
   logic [31:0] cur_rdata;

   typedef struct {
      string       tag;
      int          lat;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   assign wr_a = wr_en & ~sel;
   assign rd_a = rd_en & ~sel;
   assign wr_z = wr_en & sel;
   assign rd_z = rd_en & sel;
   assign cur_ready = sel ? ready_z : ready_a;
   assign cur_rdata = sel ? rdata_z : rdata_a;

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W_A)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(address),
      .write_data(write_data), .read_data(rdata_a), .ready(ready_a),
      .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a), .SRAM_UB_N(ub_a),
      .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
   );

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W_Z)) dut_z (
      .clk(clk), .rst(rst), .wr_en(wr_z), .rd_en(rd_z), .address(address),
      .write_data(write_data), .read_data(rdata_z), .ready(ready_z),
      .SRAM_DQ(dq_z), .SRAM_ADDR(addr_z), .SRAM_WE_N(we_z), .SRAM_UB_N(ub_z),
      .SRAM_LB_N(lb_z), .SRAM_CE_N(ce_z), .SRAM_OE_N(oe_z)
   );

   // SRAM models: drive the bus whenever not being written, capture on a low write strobe.
   assign dq_a = (!oe_a && we_a && !ce_a) ? mem_a[addr_a[5:0]] : 16'bz;
   assign dq_z = (!oe_z && we_z && !ce_z) ? mem_z[addr_z[5:0]] : 16'bz;

   always @(posedge clk) begin
      if (mdl_init) begin
         for (int i = 0; i < 64; i++) begin
            mem_a[i] <= 16'h1000 + 16'(i);
            mem_z[i] <= 16'h2000 + 16'(i);
         end
      end else begin
         if (!ce_a && !we_a) mem_a[addr_a[5:0]] <= dq_a;
         if (!ce_z && !we_z) mem_z[addr_z[5:0]] <= dq_z;
      end
   end

   always @(negedge clk) if (mon_b2b && !we_a) we_low <= we_low + 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!cur_ready && n < 50);
      if (!cur_ready) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic push_exp(input string tag, input logic [31:0] rd);
      exp_t e;
      e.tag   = tag;
      e.lat   = 3 + (sel ? W_Z : W_A);
      e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic check_done(input int n);
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_lat"}, n, e.lat);
      chk({e.tag, "_rdata"}, cur_rdata, e.rdata);
   endtask

   task automatic access(input string tag, input bit wr, input bit rd,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      int n;
      @(negedge clk);
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      push_exp(tag, exp_rd);
      #1 chk({tag, "_busy"}, cur_ready, 0);
      wait_ready(tag, n);
      check_done(n);
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b0; mdl_init = 1'b1; mon_b2b = 1'b0; sel = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; mdl_init = 1'b0;
      #1;
      chk("rst_ready", ready_a, 1);
      chk("rst_rdata", rdata_a, 0);
      chk("rst_we", we_a, 1);
      chk("rst_addr", addr_a, 0);
      chk("ties", {ub_a, lb_a, ce_a, oe_a}, 0);
      last_rd = 32'h0;

      access("wr0", 1, 0, 1024, 32'hDEADBEEF, last_rd);
      chk("wr0_w0", mem_a[0], 16'hBEEF);
      chk("wr0_w1", mem_a[1], 16'hDEAD);
      access("rd0", 0, 1, 1024, 32'h0, 32'hDEADBEEF);
      last_rd = 32'hDEADBEEF;

      access("wr6", 1, 0, 1036, 32'h12345678, last_rd);
      chk("wr6_w6", mem_a[6], 16'h5678);
      chk("wr6_w7", mem_a[7], 16'h1234);
      chk("wr6_w0", mem_a[0], 16'hBEEF);
      chk("wr6_w1", mem_a[1], 16'hDEAD);
      for (int i = 2; i < 6; i++) chk($sformatf("wr6_w%0d", i), mem_a[i], 16'h1000 + 16'(i));

      access("rd_lsb", 0, 1, 1039, 32'h0, 32'h12345678);
      last_rd = 32'h12345678;

      access("both", 1, 1, 1028, 32'hA5A55A5A, last_rd);
      chk("both_w2", mem_a[2], 16'h5A5A);
      chk("both_w3", mem_a[3], 16'hA5A5);

      access("rd_wrap", 0, 1, 1020, 32'h0, 32'h103F103E);

      // Reset asserted while the high half of a write is on the bus.
      @(negedge clk);
      wr_en = 1'b1; address = 1024; write_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 chk("abort_we_hi", we_a, 1);
      @(posedge clk); #1;
      wr_en = 1'b0; rst = 1'b1;
      #1;
      chk("abort_ready", ready_a, 1);
      chk("abort_rdata", rdata_a, 0);
      chk("abort_addr", addr_a, 0);
      @(negedge clk);
      chk("abort_w0", mem_a[0], 16'hF00D);
      chk("abort_w1", mem_a[1], 16'hDEAD);

      access("rd_after_abort", 0, 1, 1024, 32'h0, 32'hDEADF00D);

      // Back-to-back reads with rd_en held across the ready pulse.
      @(negedge clk);
      mon_b2b = 1'b1;
      rd_en = 1'b1; address = 1024;
      push_exp("b2b0", 32'hDEADF00D);
      push_exp("b2b1", 32'hA5A55A5A);
      wait_ready("b2b0", n);
      check_done(n);
      address = 1028;
      wait_ready("b2b1", n);
      chk("b2b_gap", n - 1, 5);
      check_done(3 + W_A);
      rd_en = 1'b0;
      @(negedge clk);
      mon_b2b = 1'b0;
      chk("b2b_we_low", we_low, 0);

      // Zero-settle build.
      sel = 1'b1;
      access("z_wr", 1, 0, 1032, 32'h0BADCAFE, 32'h0);
      chk("z_w4", mem_z[4], 16'hCAFE);
      chk("z_w5", mem_z[5], 16'h0BAD);
      access("z_rd", 0, 1, 1032, 32'h0, 32'h0BADCAFE);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024, the byte address that maps to SRAM word 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the idle settle cycles after the second half-word access (range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, the write request, held by the requester until ready.
REQ-006 SHALL have port rd_en, input, 1, the read request, held by the requester until ready.
REQ-007 SHALL have port address, input, 32, the byte address, held stable until ready.
REQ-008 SHALL have port write_data, input, 32, the write word, held stable until ready.
REQ-009 SHALL have port read_data, output, 32, the registered read word.
REQ-010 SHALL have port ready, output, 1, the pipeline-freeze release; 0 means stall.
REQ-011 SHALL have port SRAM_DQ, inout, 16, the SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR, output, 19, the SRAM half-word address.
REQ-013 SHALL have ports SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, output, 1 each, the active-low SRAM controls.

Function
REQ-014 SHALL use FSM states IDLE, LO, HI, WAIT, DONE.
- IDLE goes to LO when rd_en|wr_en.
- LO goes to HI.
- HI goes to WAIT, or to DONE if WAIT_CYCLES=0.
- WAIT goes to DONE after WAIT_CYCLES cycles.
- DONE goes to IDLE.
REQ-015 SHALL latch the operation type in IDLE on request; wr_en has priority when both are asserted.
REQ-016 SHALL form the word index as off = address - BASE_ADDR, modulo 2^32, and use off[19:2]; off[1:0] is ignored.
- SRAM_ADDR = {off[19:2], 1'b0} in LO.
- SRAM_ADDR = {off[19:2], 1'b1} in HI.
- SRAM_ADDR = 0 otherwise.
REQ-017 SHALL, on a write, drive SRAM_DQ = write_data[15:0] in LO and write_data[31:16] in HI, with SRAM_WE_N=0 in both states.
REQ-018 SHALL drive SRAM_WE_N=1 and SRAM_DQ=Z in every other state and for every read.
REQ-019 SHALL, on a read, register SRAM_DQ into read_data[15:0] at the end of LO and into read_data[31:16] at the end of HI; read_data holds its value otherwise, including across writes.
REQ-020 SHALL generate ready combinationally:
- ready = 0 in IDLE while rd_en|wr_en.
- ready = 0 in LO, HI and WAIT.
- ready = 1 in DONE.
- ready = 1 in IDLE with no request.
REQ-021 SHALL give fixed latency: a request first seen in IDLE at cycle 0 yields ready=1 in cycle 3+WAIT_CYCLES (cycle 5 at default), for exactly one cycle.
REQ-022 SHALL run the WAIT counter from 0 up to WAIT_CYCLES-1, clear it on leaving WAIT, and never let it wrap.
REQ-023 SHALL ignore a request still asserted in DONE; a request asserted in the following IDLE cycle starts a new access, so back-to-back accesses occur with no lost cycle beyond IDLE.
REQ-024 SHALL tie SRAM_UB_N, SRAM_LB_N, SRAM_CE_N and SRAM_OE_N to 0.
REQ-025 SHALL ignore changes to rd_en, wr_en, address and write_data in LO, HI and WAIT.

Reset
REQ-026 SHALL, when rst=0 at a clock edge, set state to IDLE, the WAIT counter to 0, read_data to 0 and the latched operation to read.
REQ-027 SHALL, on reset mid-access, abort the access at the next edge: no further SRAM_WE_N=0 cycles occur, and SRAM_DQ is Z from that edge on.
REQ-028 SHALL make ready follow REQ-020 from the IDLE state after reset.

Structure
REQ-029 SHALL place the state encoding (3-bit), BASE_ADDR and WAIT_CYCLES defaults in the shared package, alongside the SRAM width constants (DQ 16, ADDR 19).
REQ-030 SHALL be a single module; the WAIT counter is inline and no sub-module is required.

Verification (bench pairs the block with the team's 64-entry SRAM model)
REQ-031 Write then read: write 0xDEADBEEF to address 1024, then read address 1024.
- SRAM word 0 = 0xBEEF and word 1 = 0xDEAD.
- read_data = 0xDEADBEEF.
- ready rises in cycle 5 of each access.
REQ-032 Address mapping: write 0x12345678 to address 1036.
- SRAM words 6 and 7 are written.
- Words 0..5 are unchanged.
REQ-033 Simultaneous requests: rd_en=wr_en=1 at address 1028 with data 0xA5A5_5A5A.
- A write is performed.
- read_data is unchanged.
REQ-034 Reset mid-access: rst=0 in HI of a write of 0xCAFEF00D to address 1024.
- Word 0 = 0xF00D.
- Word 1 keeps its prior value.
- State returns to IDLE and ready=1 once rst=1 with no request.
REQ-035 Back-to-back reads of addresses 1024 then 1028 with rd_en held high.
- The two ready pulses are separated by exactly 5 cycles (1 IDLE + 4 busy) at WAIT_CYCLES=2.
- SRAM_DQ is never driven during reads.
REQ-036 WAIT_CYCLES=0 build: latency is 3 cycles and data is correct.
